// File: rtl/instr_mem_loader.sv
// instr_mem_loader: instruction memory with a streaming program-load engine
// and a registered, one-cycle-latency fetch port.
//
// Load handshake: a word transfers on a rising edge where load_valid and
// load_ready are both high; load_ready only depends on state and load_start,
// never on load_valid, so the producer may hold load_valid freely.
//
// The fetch port accepts a request only once a complete program is resident
// (state READY). In IDLE or LOAD it raises fetch_stall instead.
module instr_mem_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  load_overflow,
  input  logic                  fetch_en,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_valid,
  output logic                  fetch_error,
  output logic                  fetch_stall,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic load_accept;
  logic fetch_accept;
  logic fetch_in_range;

  // load_start has priority over a word offered in the same cycle
  assign load_ready     = (state == LOAD) && !load_start;
  assign load_accept    = load_valid && load_ready;
  assign fetch_accept   = fetch_en && (state == READY);
  assign fetch_stall    = fetch_en && (state != READY);
  assign fetch_in_range = {1'b0, fetch_addr} < load_count;
  assign dbg_state      = state;

  // Load-session FSM: pointer, word count and sticky completion flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      load_count    <= '0;
      load_done     <= 1'b0;
      load_overflow <= 1'b0;
    end else if (load_start) begin
      state         <= LOAD;
      ptr           <= '0;
      load_count    <= '0;
      load_done     <= 1'b0;
      load_overflow <= 1'b0;
    end else if (load_accept) begin
      ptr        <= ptr + PTR_ONE;
      load_count <= load_count + CNT_ONE;
      if (load_last) begin
        state     <= READY;
        load_done <= 1'b1;
      end else if (ptr == PTR_LAST) begin
        // Array full without a terminating word: keep what fits and flag it
        state         <= READY;
        load_done     <= 1'b1;
        load_overflow <= 1'b1;
      end
    end
  end

  // Program storage; deliberately not reset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (load_accept) begin
      mem[ptr] <= load_data;
    end
  end

  // Registered fetch port; out-of-image addresses return zero with an error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_data  <= '0;
      fetch_valid <= 1'b0;
      fetch_error <= 1'b0;
    end else if (fetch_accept) begin
      fetch_valid <= 1'b1;
      if (fetch_in_range) begin
        fetch_data  <= mem[fetch_addr];
        fetch_error <= 1'b0;
      end else begin
        fetch_data  <= '0;
        fetch_error <= 1'b1;
      end
    end else begin
      fetch_valid <= 1'b0;
      fetch_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed load/fetch sessions, a behavioural
// model compared on every falling edge, and literal spot checks.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        load_done;
  logic [6:0]  load_count;
  logic        load_overflow;
  logic        fetch_en = 1'b0;
  logic [5:0]  fetch_addr = '0;
  logic [15:0] fetch_data;
  logic        fetch_valid;
  logic        fetch_error;
  logic        fetch_stall;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  instr_mem_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
    .load_count(load_count), .load_overflow(load_overflow),
    .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .fetch_valid(fetch_valid), .fetch_error(fetch_error),
    .fetch_stall(fetch_stall), .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a session is either collecting words, or the program
  // is resident; fetches look up the model array against the word count.
  logic [15:0] m_mem [64];
  bit          m_loading, m_done, m_ovf;
  int          m_count;
  logic [15:0] m_fdata;
  bit          m_fvalid, m_ferr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading = 0; m_done = 0; m_ovf = 0; m_count = 0;
      m_fdata = '0; m_fvalid = 0; m_ferr = 0;
    end else begin
      if (fetch_en && m_done) begin
        m_fvalid = 1;
        if (int'(fetch_addr) < m_count) begin
          m_fdata = m_mem[fetch_addr]; m_ferr = 0;
        end else begin
          m_fdata = '0; m_ferr = 1;
        end
      end else begin
        m_fvalid = 0; m_ferr = 0;
      end
      if (load_start) begin
        m_loading = 1; m_done = 0; m_ovf = 0; m_count = 0;
      end else if (m_loading && load_valid) begin
        m_mem[m_count] = load_data;
        m_count++;
        if (load_last || m_count == 64) begin
          m_loading = 0; m_done = 1; m_ovf = !load_last;
        end
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model
  always @(negedge clk) begin
    check("load_ready",    32'(load_ready),    32'(m_loading && !load_start));
    check("load_done",     32'(load_done),     32'(m_done));
    check("load_count",    32'(load_count),    32'(m_count));
    check("load_overflow", 32'(load_overflow), 32'(m_ovf));
    check("fetch_data",    32'(fetch_data),    32'(m_fdata));
    check("fetch_valid",   32'(fetch_valid),   32'(m_fvalid));
    check("fetch_error",   32'(fetch_error),   32'(m_ferr));
    check("fetch_stall",   32'(fetch_stall),   32'(fetch_en && !m_done));
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch(input logic [5:0] a);
    fetch_en   = 1'b1;
    fetch_addr = a;
    tick();
    fetch_en   = 1'b0;
  endtask

  initial begin
    // reset state, with a fetch request pending
    fetch_en = 1'b1;
    repeat (3) tick();
    check("rst_done",   32'(load_done),   32'd0);
    check("rst_count",  32'(load_count),  32'd0);
    check("rst_fvalid", 32'(fetch_valid), 32'd0);
    check("rst_stall",  32'(fetch_stall), 32'd1);
    fetch_en = 1'b0;
    rst_n = 1'b1;
    tick();

    // 4-word program, then in-range and out-of-range fetches
    do_start();
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    send(16'h3333, 1'b0);
    send(16'h4444, 1'b1);
    check("p4_done",  32'(load_done),     32'd1);
    check("p4_count", 32'(load_count),    32'd4);
    check("p4_ovf",   32'(load_overflow), 32'd0);
    fetch(6'd2);
    check("f2_data",  32'(fetch_data),  32'h3333);
    check("f2_valid", 32'(fetch_valid), 32'd1);
    fetch(6'd5);
    check("f5_data",  32'(fetch_data),  32'h0000);
    check("f5_err",   32'(fetch_error), 32'd1);
    check("f5_valid", 32'(fetch_valid), 32'd1);

    // load_start in the same cycle as a fetch: fetch served, then stall
    fetch_en = 1'b1;
    fetch_addr = 6'd1;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("fs_data",  32'(fetch_data),  32'h2222);
    check("fs_valid", 32'(fetch_valid), 32'd1);
    tick();
    check("stall_valid", 32'(fetch_valid), 32'd0);
    check("stall_data",  32'(fetch_data),  32'h2222);
    fetch_en = 1'b0;

    // 64 words without load_last: truncation and overflow
    for (int i = 0; i < 64; i++) send(16'hA000 + 16'(i), 1'b0);
    check("ov_done",  32'(load_done),     32'd1);
    check("ov_flag",  32'(load_overflow), 32'd1);
    check("ov_count", 32'(load_count),    32'd64);
    check("ov_ready", 32'(load_ready),    32'd0);
    send(16'hDEAD, 1'b0);
    check("ov_count2", 32'(load_count), 32'd64);
    fetch(6'd63);
    check("ov_f63", 32'(fetch_data), 32'hA03F);
    fetch(6'd0);
    check("ov_f0", 32'(fetch_data), 32'hA000);

    // load_last on the 64th word: normal completion
    do_start();
    for (int i = 0; i < 64; i++) send(16'h5000 + 16'(i), i == 63);
    check("full_ovf",   32'(load_overflow), 32'd0);
    check("full_count", 32'(load_count),    32'd64);
    fetch(6'd63);
    check("full_f63", 32'(fetch_data), 32'h503F);

    // restart mid-session together with a valid word: word dropped
    do_start();
    send(16'h0B01, 1'b0);
    send(16'h0B02, 1'b0);
    send(16'h0B03, 1'b0);
    check("ms_count3", 32'(load_count), 32'd3);
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'h0BAD;
    tick();
    load_start = 1'b0;
    load_valid = 1'b0;
    check("ms_count0", 32'(load_count), 32'd0);
    send(16'h0C00, 1'b1);
    check("ms_count1", 32'(load_count), 32'd1);
    fetch(6'd0);
    check("ms_f0", 32'(fetch_data), 32'h0C00);
    fetch(6'd1);
    check("ms_f1_err", 32'(fetch_error), 32'd1);

    // reset in the middle of a session
    do_start();
    send(16'h0D01, 1'b0);
    send(16'h0D02, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mr_count", 32'(load_count), 32'd0);
    check("mr_ready", 32'(load_ready), 32'd0);
    check("mr_data",  32'(fetch_data), 32'd0);
    fetch_en = 1'b1;
    tick();
    check("mr_stall", 32'(fetch_stall), 32'd1);
    fetch_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    do_start();
    send(16'h0E00, 1'b1);
    check("nr_count", 32'(load_count), 32'd1);
    check("nr_done",  32'(load_done),  32'd1);
    fetch(6'd0);
    check("nr_f0", 32'(fetch_data), 32'h0E00);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
